// File: rtl/load_writeback_unit.sv
// rtl/load_writeback_unit.sv - RV32I load unit: word read handshake, align/extend, register-file writeback
module load_writeback_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        START,
    input  logic [31:0] ADDR,
    input  logic [2:0]  FUNCT3,
    input  logic [4:0]  RD,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_READY,
    input  logic        MEM_VALID,
    input  logic [31:0] MEM_RDATA,
    output logic [4:0]  AW,
    output logic [31:0] D,
    output logic        WE,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [2:0]         f3_q, f3_n;
    logic [1:0]         off_q, off_n;
    logic [4:0]         rd_q, rd_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               req_n, we_n, err_n;
    logic [31:0]        maddr_n, d_n;
    logic [4:0]         aw_n;

    logic               illegal, misaligned;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        ext_data;

    assign BUSY = (state != S_IDLE);

    always_comb begin
        illegal    = !(FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((FUNCT3[1:0] == 2'b01) && ADDR[0]) ||
                     ((FUNCT3 == 3'b010) && (ADDR[1:0] != 2'b00));
    end

    // Lane selection uses the offset latched at issue, not the live ADDR.
    always_comb begin
        byte_sel = MEM_RDATA[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        case (f3_q)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            default: ext_data = MEM_RDATA;
        endcase
    end

    always_comb begin
        state_n = state;
        f3_n    = f3_q;
        off_n   = off_q;
        rd_n    = rd_q;
        cnt_n   = cnt;
        req_n   = MEM_REQ;
        maddr_n = MEM_ADDR;
        aw_n    = AW;
        d_n     = D;
        we_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (illegal || misaligned) begin
                        err_n = 1'b1;
                    end else begin
                        f3_n    = FUNCT3;
                        off_n   = ADDR[1:0];
                        rd_n    = RD;
                        maddr_n = {ADDR[31:2], 2'b00};
                        req_n   = 1'b1;
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (MEM_READY) begin
                    req_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MEM_VALID) begin
                    d_n     = ext_data;
                    aw_n    = rd_q;
                    we_n    = (rd_q != 5'd0);
                    state_n = S_WB;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            rd_q     <= 5'd0;
            cnt      <= '0;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= 32'd0;
            AW       <= 5'd0;
            D        <= 32'd0;
            WE       <= 1'b0;
            ERR      <= 1'b0;
        end else if (CE) begin
            state    <= state_n;
            f3_q     <= f3_n;
            off_q    <= off_n;
            rd_q     <= rd_n;
            cnt      <= cnt_n;
            MEM_REQ  <= req_n;
            MEM_ADDR <= maddr_n;
            AW       <= aw_n;
            D        <= d_n;
            WE       <= we_n;
            ERR      <= err_n;
        end
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// tb/tb_load_writeback_unit.sv - directed table-driven bench for load_writeback_unit
module tb_load_writeback_unit;

    logic        CLK = 1'b0;
    logic        RST, CE, START;
    logic [31:0] ADDR;
    logic [2:0]  FUNCT3;
    logic [4:0]  RD;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_READY, MEM_VALID;
    logic [31:0] MEM_RDATA;
    logic [4:0]  AW;
    logic [31:0] D;
    logic        WE, BUSY, ERR;

    load_writeback_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .START(START), .ADDR(ADDR),
        .FUNCT3(FUNCT3), .RD(RD), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_READY(MEM_READY), .MEM_VALID(MEM_VALID), .MEM_RDATA(MEM_RDATA),
        .AW(AW), .D(D), .WE(WE), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] exp_d;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{3'b010, 32'h100, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
        vt[1]  = '{3'b000, 32'h103, 5'd1,  32'h80FF1234, 32'hFFFFFF80, 1'b1, 1'b0};
        vt[2]  = '{3'b100, 32'h103, 5'd2,  32'h80FF1234, 32'h00000080, 1'b1, 1'b0};
        vt[3]  = '{3'b001, 32'h102, 5'd3,  32'h80FF1234, 32'hFFFF80FF, 1'b1, 1'b0};
        vt[4]  = '{3'b101, 32'h102, 5'd4,  32'h80FF1234, 32'h000080FF, 1'b1, 1'b0};
        vt[5]  = '{3'b000, 32'h100, 5'd6,  32'h80FF1234, 32'h00000034, 1'b1, 1'b0};
        vt[6]  = '{3'b100, 32'h101, 5'd7,  32'h80FF1234, 32'h00000012, 1'b1, 1'b0};
        vt[7]  = '{3'b000, 32'h102, 5'd8,  32'h80FF1234, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[8]  = '{3'b001, 32'h100, 5'd31, 32'h80FF1234, 32'h00001234, 1'b1, 1'b0};
        vt[9]  = '{3'b010, 32'h102, 5'd5,  32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[10] = '{3'b001, 32'h101, 5'd5,  32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[11] = '{3'b101, 32'h103, 5'd5,  32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[12] = '{3'b011, 32'h100, 5'd5,  32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[13] = '{3'b110, 32'h100, 5'd5,  32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[14] = '{3'b111, 32'h100, 5'd5,  32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[15] = '{3'b010, 32'h204, 5'd0,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0};

        RST = 1'b1; CE = 1'b0; START = 1'b0; ADDR = 32'd0; FUNCT3 = 3'd0; RD = 5'd0;
        MEM_READY = 1'b0; MEM_VALID = 1'b0; MEM_RDATA = 32'd0;
        step;
        step;
        chk("rst_req",   {31'd0, MEM_REQ}, 32'd0);
        chk("rst_maddr", MEM_ADDR, 32'd0);
        chk("rst_aw",    {27'd0, AW}, 32'd0);
        chk("rst_d",     D, 32'd0);
        chk("rst_we",    {31'd0, WE}, 32'd0);
        chk("rst_err",   {31'd0, ERR}, 32'd0);
        chk("rst_busy",  {31'd0, BUSY}, 32'd0);
        RST = 1'b0; CE = 1'b1;
        step;

        // Table vectors: immediate READY/VALID; observe 10 cycles after issue.
        for (int i = 0; i < 16; i++) begin
            int busy_n, we_n, we_at, err_n, req_n;
            logic [31:0] got_d, got_addr;
            logic [4:0]  got_aw;
            busy_n = 0; we_n = 0; we_at = -1; err_n = 0; req_n = 0;
            got_d = 32'd0; got_addr = 32'd0; got_aw = 5'd0;
            START = 1'b1; FUNCT3 = vt[i].f3; ADDR = vt[i].addr; RD = vt[i].rd;
            MEM_READY = 1'b1; MEM_VALID = 1'b1; MEM_RDATA = vt[i].rdata;
            step;
            START = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (ERR) err_n++;
                if (MEM_REQ) begin req_n++; got_addr = MEM_ADDR; end
                if (WE) begin
                    we_n++;
                    if (we_at < 0) we_at = k;
                    got_d = D; got_aw = AW;
                end
                if (BUSY) busy_n++;
                step;
            end
            chk($sformatf("v%0d_err", i),  err_n,  {31'd0, vt[i].exp_err});
            chk($sformatf("v%0d_we", i),   we_n,   {31'd0, vt[i].exp_we});
            chk($sformatf("v%0d_busy", i), busy_n, vt[i].exp_err ? 32'd0 : 32'd3);
            chk($sformatf("v%0d_req", i),  req_n,  vt[i].exp_err ? 32'd0 : 32'd1);
            if (!vt[i].exp_err)
                chk($sformatf("v%0d_maddr", i), got_addr, {vt[i].addr[31:2], 2'b00});
            if (vt[i].exp_we) begin
                chk($sformatf("v%0d_d", i),   got_d, vt[i].exp_d);
                chk($sformatf("v%0d_aw", i),  {27'd0, got_aw}, {27'd0, vt[i].rd});
                chk($sformatf("v%0d_lat", i), we_at, 32'd2);
            end
        end
        MEM_VALID = 1'b0; MEM_READY = 1'b0;
        step;

        // Timeout with TIMEOUT=4, then a late response that must be ignored.
        begin
            int err_at, err_n, we_n, busy_n;
            err_at = -1; err_n = 0; we_n = 0; busy_n = 0;
            START = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h200; RD = 5'd7;
            MEM_READY = 1'b1; MEM_VALID = 1'b0; MEM_RDATA = 32'h55AA55AA;
            step;
            START = 1'b0;
            for (int k = 0; k < 14; k++) begin
                if (ERR) begin err_n++; if (err_at < 0) err_at = k; end
                if (WE) we_n++;
                if (BUSY) busy_n++;
                MEM_VALID = (k == 7);
                step;
            end
            MEM_VALID = 1'b0;
            chk("to_err_at", err_at, 32'd5);
            chk("to_err_n",  err_n, 32'd1);
            chk("to_we",     we_n, 32'd0);
            chk("to_busy",   busy_n, 32'd5);
        end

        // Reset in WAIT with START held high while busy.
        begin
            int req_n, we_n;
            req_n = 0; we_n = 0;
            START = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h400; RD = 5'd3;
            MEM_READY = 1'b1; MEM_VALID = 1'b0;
            step;
            for (int k = 0; k < 3; k++) begin
                if (MEM_REQ) req_n++;
                step;
            end
            chk("rw_req_once", req_n, 32'd1);
            chk("rw_busy",     {31'd0, BUSY}, 32'd1);
            START = 1'b0; RST = 1'b1;
            step;
            RST = 1'b0;
            chk("rw_req",   {31'd0, MEM_REQ}, 32'd0);
            chk("rw_maddr", MEM_ADDR, 32'd0);
            chk("rw_we",    {31'd0, WE}, 32'd0);
            chk("rw_d",     D, 32'd0);
            chk("rw_aw",    {27'd0, AW}, 32'd0);
            chk("rw_err",   {31'd0, ERR}, 32'd0);
            chk("rw_busy0", {31'd0, BUSY}, 32'd0);
            MEM_VALID = 1'b1;
            step;
            MEM_VALID = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (WE || BUSY) we_n++;
                step;
            end
            chk("rw_late_valid", we_n, 32'd0);
        end

        // CE low for three cycles while in WB.
        START = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h300; RD = 5'd9;
        MEM_READY = 1'b1; MEM_VALID = 1'b1; MEM_RDATA = 32'h12345678;
        step;
        START = 1'b0;
        step;
        step;
        chk("ce_we", {31'd0, WE}, 32'd1);
        chk("ce_d",  D, 32'h12345678);
        CE = 1'b0; MEM_RDATA = 32'h0; MEM_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("ce_hold_we%0d", k), {31'd0, WE}, 32'd1);
            chk($sformatf("ce_hold_d%0d", k),  D, 32'h12345678);
            chk($sformatf("ce_hold_aw%0d", k), {27'd0, AW}, 32'd9);
            chk($sformatf("ce_hold_busy%0d", k), {31'd0, BUSY}, 32'd1);
        end
        CE = 1'b1;
        step;
        chk("ce_we_drop", {31'd0, WE}, 32'd0);
        chk("ce_idle",    {31'd0, BUSY}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
